stripes_mac_seq: RTL and testbench

STRIPES_MAC_SEQ -- requirements
Module: stripes_mac_seq

---
 rtl/stripes_mac_seq_pkg.sv | 19 +
 rtl/stripes_mac_seq_if.sv | 31 +++
 rtl/stripes_mac_seq_adder_tree.sv | 28 ++
 rtl/stripes_mac_seq.sv | 111 +++++++++++
 tb/tb_stripes_mac_seq.sv | 130 +++++++++++++
 5 files changed

// File: rtl/stripes_mac_seq_pkg.sv
// Shared types and width helpers for the bit-serial (Stripes-style) MAC.
package stripes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Partial sum of VEC_LENGTH lanes never overflows this width.
  function automatic int psum_w(input int dw, input int n);
    return dw + $clog2(n);
  endfunction

  function automatic int bidx_w(input int mw);
    return (mw > 1) ? $clog2(mw) : 1;
  endfunction

endpackage

// File: rtl/stripes_mac_seq_if.sv
// Job/result handshake bundle for stripes_mac_seq.
interface stripes_mac_seq_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int VEC_LENGTH   = 16,
    parameter int MAX_W_BITS   = 8,
    parameter int ACC_WIDTH    = DATA_WIDTH + MAX_W_BITS + $clog2(VEC_LENGTH),
    parameter int RESULT_WIDTH = 2 * DATA_WIDTH
);
    logic                                   in_valid;
    logic                                   in_ready;
    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  act_in;
    logic [VEC_LENGTH-1:0][MAX_W_BITS-1:0]  w_in;
    logic [$clog2(MAX_W_BITS+1)-1:0]        w_prec;
    logic                                   w_signed;
    logic                                   load_accum;
    logic signed [ACC_WIDTH-1:0]            accum_prev;
    logic                                   out_valid;
    logic                                   out_ready;
    logic signed [ACC_WIDTH-1:0]            accum_out;
    logic signed [RESULT_WIDTH-1:0]         result;

    modport master (
        output in_valid, act_in, w_in, w_prec, w_signed, load_accum, accum_prev, out_ready,
        input  in_ready, out_valid, accum_out, result
    );

    modport slave (
        input  in_valid, act_in, w_in, w_prec, w_signed, load_accum, accum_prev, out_ready,
        output in_ready, out_valid, accum_out, result
    );
endinterface

// File: rtl/stripes_mac_seq_adder_tree.sv
// Gated, sign-extending binary adder tree summing the selected activation lanes.
module stripes_adder_tree
    import stripes_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LENGTH = 16
) (
    input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]          i_act,
    input  logic [VEC_LENGTH-1:0]                          i_gate,
    output logic signed [psum_w(DATA_WIDTH,VEC_LENGTH)-1:0] o_sum
);
    localparam int PSW = psum_w(DATA_WIDTH, VEC_LENGTH);

    // Heap layout: node k has children 2k+1 and 2k+2; leaves start at VEC_LENGTH-1.
    logic signed [PSW-1:0] w_node [0:2*VEC_LENGTH-2];

    genvar gi;
    generate
        for (gi = 0; gi < VEC_LENGTH; gi++) begin : g_leaf
            assign w_node[VEC_LENGTH-1+gi] = i_gate[gi] ? PSW'($signed(i_act[gi])) : '0;
        end
        for (gi = 0; gi < VEC_LENGTH-1; gi++) begin : g_node
            assign w_node[gi] = w_node[2*gi+1] + w_node[2*gi+2];
        end
    endgenerate

    assign o_sum = w_node[0];
endmodule

// File: rtl/stripes_mac_seq.sv
// Bit-serial vector MAC: one weight bit-plane per cycle, shift-accumulated, saturated output.
module stripes_mac_seq
    import stripes_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int VEC_LENGTH   = 16,
    parameter int MAX_W_BITS   = 8,
    parameter int ACC_WIDTH    = DATA_WIDTH + MAX_W_BITS + $clog2(VEC_LENGTH),
    parameter int RESULT_WIDTH = 2 * DATA_WIDTH
) (
    input logic              clk,
    input logic              reset,
    stripes_mac_seq_if.slave bus
);
    localparam int PSW = psum_w(DATA_WIDTH, VEC_LENGTH);
    localparam int BW  = bidx_w(MAX_W_BITS);
    localparam int PW  = $clog2(MAX_W_BITS + 1);

    state_t                                r_state;
    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] r_act;
    logic [VEC_LENGTH-1:0][MAX_W_BITS-1:0] r_w;
    logic [PW-1:0]                         r_p;
    logic                                  r_sgn;
    logic [BW-1:0]                         r_b;
    logic signed [ACC_WIDTH-1:0]           r_acc;

    logic                                  w_accept;
    logic [PW-1:0]                         w_peff;
    logic [VEC_LENGTH-1:0]                 w_gate;
    logic signed [PSW-1:0]                 w_psum;
    logic signed [PSW:0]                   w_pext;
    logic signed [PSW:0]                   w_px;
    logic                                  w_last;
    logic signed [ACC_WIDTH-1:0]           w_term;

    assign w_accept = (r_state == IDLE) && bus.in_valid;
    assign w_peff   = (bus.w_prec == '0 || bus.w_prec > PW'(MAX_W_BITS)) ? PW'(MAX_W_BITS)
                                                                        : bus.w_prec;

    genvar gl;
    generate
        for (gl = 0; gl < VEC_LENGTH; gl++) begin : g_gate
            assign w_gate[gl] = r_w[gl][r_b];
        end
    endgenerate

    stripes_adder_tree #(
        .DATA_WIDTH (DATA_WIDTH),
        .VEC_LENGTH (VEC_LENGTH)
    ) u_tree (
        .i_act  (r_act),
        .i_gate (w_gate),
        .o_sum  (w_psum)
    );

    // The MSB plane of a two's-complement weight carries negative weight.
    assign w_last = (PW'(r_b) == r_p - PW'(1));
    assign w_pext = (PSW+1)'(w_psum);
    assign w_px   = (r_sgn && w_last) ? -w_pext : w_pext;
    assign w_term = ACC_WIDTH'(w_px) <<< r_b;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_act <= bus.act_in;
            r_w   <= bus.w_in;
            r_p   <= w_peff;
            r_sgn <= bus.w_signed;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_b     <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_acc   <= bus.load_accum ? bus.accum_prev : '0;
                    r_b     <= '0;
                    r_state <= RUN;
                end
                RUN: begin
                    r_acc <= r_acc + w_term;
                    if (w_last) r_state <= DONE;
                    else        r_b     <= r_b + BW'(1);
                end
                DONE: if (bus.out_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.accum_out = r_acc;

    generate
        if (RESULT_WIDTH < ACC_WIDTH) begin : g_sat
            localparam logic signed [ACC_WIDTH-1:0] R_MAX =
                {{(ACC_WIDTH-RESULT_WIDTH+1){1'b0}}, {(RESULT_WIDTH-1){1'b1}}};
            localparam logic signed [ACC_WIDTH-1:0] R_MIN =
                {{(ACC_WIDTH-RESULT_WIDTH+1){1'b1}}, {(RESULT_WIDTH-1){1'b0}}};
            assign bus.result = (r_acc > R_MAX) ? RESULT_WIDTH'(R_MAX) :
                                (r_acc < R_MIN) ? RESULT_WIDTH'(R_MIN) :
                                                  RESULT_WIDTH'(r_acc);
        end else begin : g_nosat
            assign bus.result = RESULT_WIDTH'(r_acc);
        end
    endgenerate
endmodule

// File: tb/tb_stripes_mac_seq.sv
// Directed self-checking bench for stripes_mac_seq with hand-computed expectations.
module tb_stripes_mac_seq;
    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    stripes_mac_seq_if bus ();

    stripes_mac_seq u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One job: uniform act/weight across lanes; hold = DONE cycles with out_ready low.
    task automatic job(input string tag, input logic [7:0] a, input logic [7:0] w,
                       input logic sg, input int pr, input logic ld, input int prev,
                       input int eacc, input int eres, input int elat, input int hold);
        int cyc;
        @(negedge clk);
        chk({tag, "_in_ready_idle"}, bus.in_ready, 1);
        bus.act_in     = {16{a}};
        bus.w_in       = {16{w}};
        bus.w_signed   = sg;
        bus.w_prec     = 4'(pr);
        bus.load_accum = ld;
        bus.accum_prev = 20'(prev);
        bus.in_valid   = 1'b1;
        bus.out_ready  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        // Garbage on the inputs while busy must not disturb the job.
        bus.act_in     = {4{$urandom}};
        bus.w_in       = {4{$urandom}};
        bus.w_prec     = 4'($urandom_range(0, 15));
        bus.load_accum = 1'b1;
        bus.accum_prev = 20'h7ffff;
        bus.out_ready  = 1'b1;
        chk({tag, "_in_ready_busy"}, bus.in_ready, 0);
        cyc = 1;
        while (!bus.out_valid && cyc < 40) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk({tag, "_latency"}, cyc, elat);
        chk({tag, "_accum"}, bus.accum_out, eacc);
        chk({tag, "_result"}, bus.result, eres);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, bus.out_valid, 1);
            chk({tag, "_hold_result"}, bus.result, eres);
            chk({tag, "_hold_in_ready"}, bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_back_idle"}, bus.in_ready, 1);
        chk({tag, "_valid_drop"}, bus.out_valid, 0);
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.act_in     = '0;
        bus.w_in       = '0;
        bus.w_prec     = '0;
        bus.w_signed   = 1'b0;
        bus.load_accum = 1'b0;
        bus.accum_prev = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_accum", bus.accum_out, 0);
        chk("rst_result", bus.result, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);

        job("ones",     8'h01, 8'h01, 1'b0, 8, 1'b0, 0,   16,      16,     9, 0);
        job("neg_one",  8'h03, 8'hFF, 1'b1, 8, 1'b0, 0,   -48,     -48,    9, 0);
        job("sat_pos",  8'h80, 8'h80, 1'b1, 8, 1'b0, 0,   262144,  32767,  9, 0);
        job("p4_seed",  8'h05, 8'hFF, 1'b1, 4, 1'b1, 100, 20,      20,     5, 3);
        job("p0_max",   8'h01, 8'h80, 1'b0, 0, 1'b0, 0,   2048,    2048,   9, 0);
        job("p9_max",   8'h01, 8'h80, 1'b0, 9, 1'b0, 0,   2048,    2048,   9, 0);
        job("p2_mask",  8'h02, 8'hFF, 1'b0, 2, 1'b0, 0,   96,      96,     3, 0);
        job("sat_neg",  8'h80, 8'h7F, 1'b1, 8, 1'b0, 0,   -260096, -32768, 9, 0);

        // Reset while the bit index sits at 3.
        @(negedge clk);
        bus.act_in     = {16{8'h01}};
        bus.w_in       = {16{8'h01}};
        bus.w_signed   = 1'b0;
        bus.w_prec     = 4'd8;
        bus.load_accum = 1'b0;
        bus.in_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_accum", bus.accum_out, 16);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_accum", bus.accum_out, 0);
        chk("mid_rst_result", bus.result, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);
        job("after_rst", 8'h01, 8'h01, 1'b0, 8, 1'b0, 0, 16, 16, 9, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
